regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the single write port (WE3/WD3/rd) of the register file. Two producers share the port through one-entry holding buffers with valid/ready handshakes: the ALU result path and the load/memory result path. The arbiter orders writes oldest-first and drives registered write controls into the register file. It also reports read-after-write hazards for the decode-stage source registers.

---
 rtl/regfile_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// ALU and memory results each sit in a one-entry buffer. Writes are granted
// oldest-first. Same-edge ties alternate through a round-robin pointer.
// The write controls (WE3/A3/WD3) are registered.
module regfile_wb_arbiter #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_wd,
    output logic                     alu_ready,
    input  logic                     mem_valid,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_ready,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] A3,
    output logic [DATA_WIDTH-1:0]    WD3,
    input  logic [ADDRESS_WIDTH-1:0] rs1,
    input  logic [ADDRESS_WIDTH-1:0] rs2,
    output logic                     hazard1,
    output logic                     hazard2,
    output logic                     busy
);

    // Buffer state. A young flag of 1 means the entry arrived after the other buffer's entry.
    logic                     alu_full_q, mem_full_q;
    logic                     alu_young_q, mem_young_q;
    logic [ADDRESS_WIDTH-1:0] alu_rd_q, mem_rd_q;
    logic [DATA_WIDTH-1:0]    alu_wd_q, mem_wd_q;
    // Round-robin pointer: 0 favours ALU, 1 favours memory.
    logic                     rr_q;
    logic                     we3_q;
    logic [ADDRESS_WIDTH-1:0] a3_q;
    logic [DATA_WIDTH-1:0]    wd3_q;

    logic                     grant_alu, grant_mem, grant_tie;
    logic                     alu_acc, mem_acc;
    logic [ADDRESS_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0]    grant_wd;

    // Grant selection: a lone full buffer wins, otherwise the older one, otherwise round-robin.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        grant_tie = 1'b0;
        if (alu_full_q && mem_full_q) begin
            if (alu_young_q != mem_young_q) begin
                grant_alu = mem_young_q;
                grant_mem = alu_young_q;
            end else begin
                grant_tie = 1'b1;
                grant_alu = ~rr_q;
                grant_mem = rr_q;
            end
        end else begin
            grant_alu = alu_full_q;
            grant_mem = mem_full_q;
        end
    end

    // Mux the granted entry toward the output stage.
    always_comb begin
        grant_rd = mem_rd_q;
        grant_wd = mem_wd_q;
        if (grant_alu) begin
            grant_rd = alu_rd_q;
            grant_wd = alu_wd_q;
        end
    end

    // A buffer draining this cycle can be refilled on the same edge.
    assign alu_ready = !alu_full_q || grant_alu;
    assign mem_ready = !mem_full_q || grant_mem;
    assign alu_acc   = alu_valid && alu_ready;
    assign mem_acc   = mem_valid && mem_ready;

    // Buffer fill/drain and age tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_full_q  <= 1'b0;
            alu_young_q <= 1'b0;
            alu_rd_q    <= '0;
            alu_wd_q    <= '0;
            mem_full_q  <= 1'b0;
            mem_young_q <= 1'b0;
            mem_rd_q    <= '0;
            mem_wd_q    <= '0;
        end else begin
            if (alu_acc) begin
                alu_full_q  <= 1'b1;
                alu_rd_q    <= alu_rd;
                alu_wd_q    <= alu_wd;
                // The new entry is younger only if the memory entry survives this edge.
                alu_young_q <= mem_full_q && !grant_mem;
            end else if (grant_alu) begin
                alu_full_q  <= 1'b0;
                alu_young_q <= 1'b0;
            end else if (grant_mem) begin
                alu_young_q <= 1'b0;
            end

            if (mem_acc) begin
                mem_full_q  <= 1'b1;
                mem_rd_q    <= mem_rd;
                mem_wd_q    <= mem_wd;
                mem_young_q <= alu_full_q && !grant_alu;
            end else if (grant_mem) begin
                mem_full_q  <= 1'b0;
                mem_young_q <= 1'b0;
            end else if (grant_alu) begin
                mem_young_q <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves only when it actually broke a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else if (grant_tie) begin
            rr_q <= ~rr_q;
        end
    end

    // Registered write port. A write to x0 is consumed without asserting WE3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else if (grant_alu || grant_mem) begin
            we3_q <= (grant_rd != '0);
            a3_q  <= grant_rd;
            wd3_q <= grant_wd;
        end else begin
            we3_q <= 1'b0;
        end
    end

    assign WE3 = we3_q;
    assign A3  = a3_q;
    assign WD3 = wd3_q;

    // A source is hazardous while any write to it is still buffered or in flight on the port.
    assign hazard1 = (rs1 != '0) && ((alu_full_q && (alu_rd_q == rs1)) ||
                                     (mem_full_q && (mem_rd_q == rs1)) ||
                                     (we3_q && (a3_q == rs1)));
    assign hazard2 = (rs2 != '0) && ((alu_full_q && (alu_rd_q == rs2)) ||
                                     (mem_full_q && (mem_rd_q == rs2)) ||
                                     (we3_q && (a3_q == rs2)));

    assign busy = alu_full_q || mem_full_q || we3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter plus a queue-model stream check.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [31:0] alu_wd, mem_wd;
    logic        alu_ready, mem_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [4:0]  rs1, rs2;
    logic        hazard1, hazard2, busy;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(
        .ADDRESS_WIDTH(5),
        .DATA_WIDTH   (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_valid(alu_valid),
        .alu_rd   (alu_rd),
        .alu_wd   (alu_wd),
        .alu_ready(alu_ready),
        .mem_valid(mem_valid),
        .mem_rd   (mem_rd),
        .mem_wd   (mem_wd),
        .mem_ready(mem_ready),
        .WE3      (WE3),
        .A3       (A3),
        .WD3      (WD3),
        .rs1      (rs1),
        .rs2      (rs2),
        .hazard1  (hazard1),
        .hazard2  (hazard2),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef logic [36:0] entry_t;
    entry_t q[$];
    entry_t e;
    logic   acc_a, acc_m;
    bit     rr_m;
    int     na, nm, nacc, nwr;

    initial begin
        rst = 1'b1;
        alu_valid = 0; mem_valid = 0;
        alu_rd = 0; alu_wd = 0; mem_rd = 0; mem_wd = 0;
        rs1 = 0; rs2 = 0;
        #1;
        check_eq("rst_we3", WE3, 0);
        check_eq("rst_a3", A3, 0);
        check_eq("rst_wd3", WD3, 0);
        check_eq("rst_ready", {alu_ready, mem_ready}, 2'b11);
        check_eq("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset while the ALU buffer holds an entry.
        alu_valid = 1; alu_rd = 9; alu_wd = 32'h55; rs1 = 9;
        tick();
        alu_valid = 0;
        check_eq("pre_rst_haz", hazard1, 1);
        check_eq("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_we3", WE3, 0);
        check_eq("mid_rst_ready", alu_ready, 1);
        check_eq("mid_rst_haz", hazard1, 0);
        check_eq("mid_rst_busy", busy, 0);
        #1 rst = 1'b0;
        tick();
        check_eq("post_rst_we3a", WE3, 0);
        tick();
        check_eq("post_rst_we3b", WE3, 0);

        // Single uncontended write.
        alu_valid = 1; alu_rd = 5; alu_wd = 32'hDEADBEEF; rs1 = 5;
        tick();
        alu_valid = 0;
        check_eq("single_c1_we3", WE3, 0);
        check_eq("single_c1_haz", hazard1, 1);
        check_eq("single_c1_ready", alu_ready, 1);
        tick();
        check_eq("single_c2_we3", WE3, 1);
        check_eq("single_c2_a3", A3, 5);
        check_eq("single_c2_wd3", WD3, 32'hDEADBEEF);
        check_eq("single_c2_haz", hazard1, 1);
        tick();
        check_eq("single_c3_we3", WE3, 0);
        check_eq("single_c3_haz", hazard1, 0);
        check_eq("single_c3_a3", A3, 5);
        rs1 = 0;

        // Same-edge tie twice: ALU wins first, then memory.
        for (int r = 0; r < 2; r++) begin
            alu_valid = 1; alu_rd = 3; alu_wd = 1;
            mem_valid = 1; mem_rd = 4; mem_wd = 2;
            tick();
            alu_valid = 0; mem_valid = 0;
            check_eq("tie_alu_ready", alu_ready, (r == 0) ? 1 : 0);
            check_eq("tie_mem_ready", mem_ready, (r == 0) ? 0 : 1);
            tick();
            check_eq("tie_w1_we3", WE3, 1);
            check_eq("tie_w1_a3", A3, (r == 0) ? 3 : 4);
            check_eq("tie_w1_wd3", WD3, (r == 0) ? 1 : 2);
            check_eq("tie_ready_back", {alu_ready, mem_ready}, 2'b11);
            tick();
            check_eq("tie_w2_we3", WE3, 1);
            check_eq("tie_w2_a3", A3, (r == 0) ? 4 : 3);
            check_eq("tie_w2_wd3", WD3, (r == 0) ? 2 : 1);
            tick();
            check_eq("tie_idle_we3", WE3, 0);
        end

        // Same rd from different edges lands oldest-first.
        alu_valid = 1; alu_rd = 1; alu_wd = 32'h11;
        tick();
        alu_valid = 0;
        mem_valid = 1; mem_rd = 7; mem_wd = 32'hA; rs2 = 7;
        tick();
        mem_valid = 0;
        check_eq("order_e1_a3", A3, 1);
        check_eq("order_e1_haz2", hazard2, 1);
        alu_valid = 1; alu_rd = 7; alu_wd = 32'hB;
        tick();
        alu_valid = 0;
        check_eq("order_e2_we3", WE3, 1);
        check_eq("order_e2_a3", A3, 7);
        check_eq("order_e2_wd3", WD3, 32'hA);
        tick();
        check_eq("order_e3_we3", WE3, 1);
        check_eq("order_e3_a3", A3, 7);
        check_eq("order_e3_wd3", WD3, 32'hB);
        tick();
        check_eq("order_idle_we3", WE3, 0);
        check_eq("order_idle_haz2", hazard2, 0);
        rs2 = 0;

        // Write to x0 is consumed silently.
        alu_valid = 1; alu_rd = 0; alu_wd = 32'h1234;
        tick();
        alu_valid = 0;
        check_eq("x0_haz", {hazard1, hazard2}, 2'b00);
        check_eq("x0_busy", busy, 1);
        tick();
        check_eq("x0_we3", WE3, 0);
        check_eq("x0_wd3", WD3, 32'h1234);
        check_eq("x0_busy_done", busy, 0);
        check_eq("x0_ready", alu_ready, 1);
        tick();

        // Continuous requests from both sides against an oldest-first queue model.
        rr_m = 0; na = 0; nm = 0; nacc = 0; nwr = 0;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) begin
                alu_valid = 1; alu_rd = 5'(na % 31 + 1); alu_wd = 32'hA000 + 32'(na);
                mem_valid = 1; mem_rd = 5'((nm * 7) % 31 + 1); mem_wd = 32'hB000 + 32'(nm);
            end else begin
                alu_valid = 0; mem_valid = 0;
            end
            acc_a = alu_valid && alu_ready;
            acc_m = mem_valid && mem_ready;
            tick();
            if (q.size() > 0) begin
                e = q.pop_front();
                check_eq("stream_we3", WE3, 1);
                check_eq("stream_a3", A3, e[36:32]);
                check_eq("stream_wd3", WD3, e[31:0]);
            end else begin
                check_eq("stream_idle", WE3, 0);
            end
            if (WE3) nwr++;
            if (acc_a && acc_m) begin
                if (!rr_m) begin
                    q.push_back({alu_rd, alu_wd});
                    q.push_back({mem_rd, mem_wd});
                end else begin
                    q.push_back({mem_rd, mem_wd});
                    q.push_back({alu_rd, alu_wd});
                end
                rr_m = !rr_m;
            end else if (acc_a) begin
                q.push_back({alu_rd, alu_wd});
            end else if (acc_m) begin
                q.push_back({mem_rd, mem_wd});
            end
            if (acc_a) begin na++; nacc++; end
            if (acc_m) begin nm++; nacc++; end
        end
        check_eq("stream_drained", 64'(q.size()), 0);
        check_eq("stream_accepts", 64'(nacc), 21);
        check_eq("stream_writes", 64'(nwr), 21);
        check_eq("stream_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
